tcp_buf_ring_ctrl: RTL and testbench
====================================

TCP_BUF_RING_CTRL -- requirements
Module: tcp_buf_ring_ctrl

Interface
REQ-001 SHALL have parameter FLOWID_W, default 3, flow id width; NUM_FLOWS = 2**FLOWID_W.
REQ-002 SHALL have parameter RING_DEPTH, fixed 8 (MAX_NUM_BUFS), buffer slots per flow; index width 4 (3 slot bits + 1 wrap bit).
REQ-003 SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports post_val/post_rdy  in/out  1 each  producer append handshake.
REQ-006 SHALL have ports post_flowid  input  FLOWID_W, and post_buf  input  TCP_BUF_W (tcp_buf)  descriptor to append.
REQ-007 SHALL have ports req_val/req_rdy  in/out  1 each, and req_flowid  input  FLOWID_W  app buffer request.
REQ-008 SHALL have ports resp_val/resp_rdy  out/in  1 each  response handshake.
REQ-009 SHALL have ports resp_flowid  output  FLOWID_W, resp_buf  output  TCP_BUF_WITH_IDX_W, resp_empty  output  1.
REQ-010 SHALL have ports adj_val/adj_rdy  in/out  1 each, adj_flowid  input  FLOWID_W, adj_update  input  TCP_BUF_UPDATE_W (tcp_buf_update).
REQ-011 SHALL have port adj_err  output  1  one-cycle pulse on a rejected adjust.

Function
REQ-012 SHALL keep per-flow 4-bit head and tail indices in flops and a NUM_FLOWS x 8 descriptor RAM addressed {flowid, idx[2:0]}.
REQ-013 SHALL define empty = (head == tail); full = (head[3] != tail[3]) and (head[2:0] == tail[2:0]).
REQ-014 SHALL grant at most one of post/req/adj per cycle, round-robin in order post -> req -> adj -> post, pointer moving to the requester after the one granted; idle cycles do not move the pointer.
REQ-015 SHALL assert each *_rdy combinationally only in the cycle its valid is granted; req additionally requires FSM in IDLE.
REQ-016 SHALL, on a granted post to a non-full flow, write post_buf at tail and increment tail mod 16 at the clock edge.
REQ-017 SHALL, on a granted post to a full flow, drop the descriptor, leave tail unchanged, and pulse adj_err the next cycle.
REQ-018 SHALL have FSM states IDLE and RESP_WAIT; a granted req moves IDLE -> RESP_WAIT.
REQ-019 SHALL present resp_val the cycle after req grant: resp_flowid = req_flowid; if non-empty, resp_buf = {descriptor at head, head}, resp_empty = 0; if empty, resp_buf = 0, resp_empty = 1.
REQ-020 SHALL hold resp_* stable while resp_val=1 and resp_rdy=0; RESP_WAIT -> IDLE on resp_val and resp_rdy.
REQ-021 SHALL continue granting post/adj during RESP_WAIT without altering the captured response.
REQ-022 SHALL accept a granted adjust only if bufs_consumed == 1, leftover_bytes_consumed == 0, flow non-empty, and prev_buf.idx == head; then head increments mod 16.
REQ-023 SHALL, on any adjust check failure, leave head unchanged and pulse adj_err the cycle after grant.
REQ-024 SHALL treat index wrap 15 -> 0 as ordinary modulo-16 arithmetic; full/empty SHALL remain correct across wrap.

Reset
REQ-025 SHALL, at a clock edge with rst=1, set all heads and tails to 0, FSM to IDLE, RR pointer to post, resp_val=0, resp_buf=0, resp_empty=0, resp_flowid=0, adj_err=0; all *_rdy SHALL be 0 while rst=1.
REQ-026 SHALL NOT reset descriptor RAM; an in-flight response SHALL be discarded by reset.

Verification
REQ-027 SHALL cover post 3 descriptors to flow 2, then req flow 2 -> resp_val one cycle later, resp_buf.idx=0, resp_empty=0, ptr equal to first posted.
REQ-028 SHALL cover req on flow 5 after reset -> resp_empty=1, resp_buf=0; hold resp_rdy=0 for 4 cycles -> outputs stable, req_rdy=0.
REQ-029 SHALL cover posting 9 descriptors to flow 1 -> 9th dropped with adj_err pulse, tail=8 (4'b1000); then 8 valid adjusts -> head=8, empty.
REQ-030 SHALL cover adjust with prev_buf.idx=1 while head=0 -> adj_err=1, head stays 0; adjust with bufs_consumed=2 -> adj_err=1.
REQ-031 SHALL cover post/req/adj all valid continuously for 6 cycles -> grants post, req, adj, post, (req blocked if in RESP_WAIT -> adj), fair order checked.
REQ-032 SHALL cover 20 post/adjust pairs on flow 0 -> indices wrap past 15 to 0, never falsely full or empty.

Source files
------------

// File: rtl/tcp_buf_ring_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_buf_ring_ctrl_if
//  Description : Bundle of the producer post, application request/response
//                and head-adjust handshakes of the TCP buffer ring controller.
//                Descriptor layouts (MSB first):
//                  tcp_buf          = {ptr[15:0], len[15:0]}  (TCP_BUF_W bits)
//                  tcp_buf_with_idx = {tcp_buf, idx[3:0]}
//                  tcp_buf_update   = {prev_buf (tcp_buf_with_idx),
//                                      bufs_consumed[3:0],
//                                      leftover_bytes_consumed[15:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
interface tcp_buf_ring_ctrl_if #(
   parameter int FLOWID_W  = 3,
   parameter int TCP_BUF_W = 32
);
   localparam int IDX_W              = 4;
   localparam int TCP_BUF_WITH_IDX_W = TCP_BUF_W + IDX_W;
   localparam int TCP_BUF_UPDATE_W   = TCP_BUF_WITH_IDX_W + 4 + 16;

   logic                          post_val;
   logic                          post_rdy;
   logic [FLOWID_W-1:0]           post_flowid;
   logic [TCP_BUF_W-1:0]          post_buf;

   logic                          req_val;
   logic                          req_rdy;
   logic [FLOWID_W-1:0]           req_flowid;

   logic                          resp_val;
   logic                          resp_rdy;
   logic [FLOWID_W-1:0]           resp_flowid;
   logic [TCP_BUF_WITH_IDX_W-1:0] resp_buf;
   logic                          resp_empty;

   logic                          adj_val;
   logic                          adj_rdy;
   logic [FLOWID_W-1:0]           adj_flowid;
   logic [TCP_BUF_UPDATE_W-1:0]   adj_update;
   logic                          adj_err;

   // Requester side: producer, application and consumer logic
   modport master (
      output post_val, post_flowid, post_buf,
      input  post_rdy,
      output req_val, req_flowid,
      input  req_rdy,
      input  resp_val, resp_flowid, resp_buf, resp_empty,
      output resp_rdy,
      output adj_val, adj_flowid, adj_update,
      input  adj_rdy, adj_err
   );

   // Ring controller side
   modport slave (
      input  post_val, post_flowid, post_buf,
      output post_rdy,
      input  req_val, req_flowid,
      output req_rdy,
      output resp_val, resp_flowid, resp_buf, resp_empty,
      input  resp_rdy,
      input  adj_val, adj_flowid, adj_update,
      output adj_rdy, adj_err
   );
endinterface
`default_nettype wire

// File: rtl/tcp_buf_ring_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tcp_buf_ring_ctrl
//  Description : Per-flow ring of receive buffer descriptors. Producers append
//                descriptors at the tail, the application reads the descriptor
//                at the head, and the consumer retires it by adjusting the
//                head. One of post/req/adj is served per cycle, round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module tcp_buf_ring_ctrl #(
   parameter int FLOWID_W   = 3,
   parameter int RING_DEPTH = 8,
   parameter int TCP_BUF_W  = 32
) (
   input  wire logic             clk,
   input  wire logic             rst,
   tcp_buf_ring_ctrl_if.slave    bus
);
   localparam int NUM_FLOWS          = 2 ** FLOWID_W;
   localparam int SLOT_W             = $clog2(RING_DEPTH);
   localparam int IDX_W              = SLOT_W + 1;
   localparam int TCP_BUF_WITH_IDX_W = TCP_BUF_W + IDX_W;

   // Field positions inside tcp_buf_update
   localparam int LEFT_LSB  = 0;
   localparam int CNT_LSB   = 16;
   localparam int PIDX_LSB  = 20;
   localparam int PBUF_LSB  = PIDX_LSB + IDX_W;
   localparam int UPD_MSB   = PBUF_LSB + TCP_BUF_W - 1;

   // Round-robin pointer encodings: who gets first look next cycle
   localparam logic [1:0] c_PTR_POST = 2'd0;
   localparam logic [1:0] c_PTR_REQ  = 2'd1;
   localparam logic [1:0] c_PTR_ADJ  = 2'd2;

   typedef enum logic [0:0] {
      S_IDLE      = 1'b0,
      S_RESP_WAIT = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0]     r_head [NUM_FLOWS];
   logic [IDX_W-1:0]     r_tail [NUM_FLOWS];
   logic [TCP_BUF_W-1:0] r_ram  [NUM_FLOWS*RING_DEPTH];

   logic [1:0]                    r_rr_ptr;
   state_t                        r_state;
   logic                          r_resp_val;
   logic [FLOWID_W-1:0]           r_resp_flowid;
   logic [TCP_BUF_WITH_IDX_W-1:0] r_resp_buf;
   logic                          r_resp_empty;
   logic                          r_adj_err;

   // ---------------------------------------------------------------------
   // Per-source ring status
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0]     w_post_head, w_post_tail;
   logic [IDX_W-1:0]     w_req_head,  w_req_tail;
   logic [IDX_W-1:0]     w_adj_head,  w_adj_tail;
   logic                 w_post_full, w_req_empty, w_adj_empty;
   logic [TCP_BUF_W-1:0] w_req_desc;
   logic [15:0]          w_adj_left;
   logic [3:0]           w_adj_cnt;
   logic [IDX_W-1:0]     w_adj_pidx;
   logic                 w_adj_ok;
   logic                 w_unused_prev_desc;

   assign w_post_head = r_head[bus.post_flowid];
   assign w_post_tail = r_tail[bus.post_flowid];
   assign w_req_head  = r_head[bus.req_flowid];
   assign w_req_tail  = r_tail[bus.req_flowid];
   assign w_adj_head  = r_head[bus.adj_flowid];
   assign w_adj_tail  = r_tail[bus.adj_flowid];

   // Full when the slot bits match but the wrap bits differ
   assign w_post_full = (w_post_head[IDX_W-1] != w_post_tail[IDX_W-1]) &&
                        (w_post_head[SLOT_W-1:0] == w_post_tail[SLOT_W-1:0]);
   assign w_req_empty = (w_req_head == w_req_tail);
   assign w_adj_empty = (w_adj_head == w_adj_tail);

   assign w_req_desc  = r_ram[{bus.req_flowid, w_req_head[SLOT_W-1:0]}];

   assign w_adj_left  = bus.adj_update[LEFT_LSB +: 16];
   assign w_adj_cnt   = bus.adj_update[CNT_LSB  +: 4];
   assign w_adj_pidx  = bus.adj_update[PIDX_LSB +: IDX_W];
   // Only the index of prev_buf matters for retiring the head descriptor
   assign w_unused_prev_desc = ^bus.adj_update[UPD_MSB:PBUF_LSB];

   assign w_adj_ok = (w_adj_cnt == 4'd1) && (w_adj_left == 16'd0) &&
                     !w_adj_empty && (w_adj_pidx == w_adj_head);

   // ---------------------------------------------------------------------
   // Arbitration: bit0 = post, bit1 = req, bit2 = adj
   // ---------------------------------------------------------------------
   logic [2:0] w_cand;
   logic [2:0] w_gnt;

   assign w_cand = {bus.adj_val, bus.req_val && (r_state == S_IDLE), bus.post_val};

   // Round-robin pick starting at the pointer; nothing granted in reset
   always_comb begin
      w_gnt = 3'b000;
      if (!rst) begin
         case (r_rr_ptr)
            c_PTR_REQ: begin
               if      (w_cand[1]) w_gnt = 3'b010;
               else if (w_cand[2]) w_gnt = 3'b100;
               else if (w_cand[0]) w_gnt = 3'b001;
            end
            c_PTR_ADJ: begin
               if      (w_cand[2]) w_gnt = 3'b100;
               else if (w_cand[0]) w_gnt = 3'b001;
               else if (w_cand[1]) w_gnt = 3'b010;
            end
            default: begin
               if      (w_cand[0]) w_gnt = 3'b001;
               else if (w_cand[1]) w_gnt = 3'b010;
               else if (w_cand[2]) w_gnt = 3'b100;
            end
         endcase
      end
   end

   assign bus.post_rdy    = w_gnt[0];
   assign bus.req_rdy     = w_gnt[1];
   assign bus.adj_rdy     = w_gnt[2];
   assign bus.resp_val    = r_resp_val;
   assign bus.resp_flowid = r_resp_flowid;
   assign bus.resp_buf    = r_resp_buf;
   assign bus.resp_empty  = r_resp_empty;
   assign bus.adj_err     = r_adj_err;

   // Descriptor RAM write on an accepted post (contents survive reset)
   always_ff @(posedge clk) begin
      if (w_gnt[0] && !w_post_full) begin
         r_ram[{bus.post_flowid, w_post_tail[SLOT_W-1:0]}] <= bus.post_buf;
      end
   end

   // Ring indices, round-robin pointer and the reject pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int f = 0; f < NUM_FLOWS; f++) begin
            r_head[f] <= '0;
            r_tail[f] <= '0;
         end
         r_rr_ptr  <= c_PTR_POST;
         r_adj_err <= 1'b0;
      end else begin
         r_adj_err <= (w_gnt[0] && w_post_full) || (w_gnt[2] && !w_adj_ok);
         if (w_gnt[0] && !w_post_full) begin
            r_tail[bus.post_flowid] <= w_post_tail + IDX_W'(1);
         end
         if (w_gnt[2] && w_adj_ok) begin
            r_head[bus.adj_flowid] <= w_adj_head + IDX_W'(1);
         end
         if (w_gnt[0])      r_rr_ptr <= c_PTR_REQ;
         else if (w_gnt[1]) r_rr_ptr <= c_PTR_ADJ;
         else if (w_gnt[2]) r_rr_ptr <= c_PTR_POST;
      end
   end

   // Request FSM: capture the head descriptor, hold it until accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_resp_val    <= 1'b0;
         r_resp_flowid <= '0;
         r_resp_buf    <= '0;
         r_resp_empty  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt[1]) begin
                  r_state       <= S_RESP_WAIT;
                  r_resp_val    <= 1'b1;
                  r_resp_flowid <= bus.req_flowid;
                  if (w_req_empty) begin
                     r_resp_buf   <= '0;
                     r_resp_empty <= 1'b1;
                  end else begin
                     r_resp_buf   <= {w_req_desc, w_req_head};
                     r_resp_empty <= 1'b0;
                  end
               end
            end
            S_RESP_WAIT: begin
               if (r_resp_val && bus.resp_rdy) begin
                  r_state    <= S_IDLE;
                  r_resp_val <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_tcp_buf_ring_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tcp_buf_ring_ctrl
//  Description : Directed scoreboard bench for tcp_buf_ring_ctrl. Expected
//                responses and reject pulses are queued as stimulus is
//                issued; a monitor compares them as the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tcp_buf_ring_ctrl;
   localparam int FW = 3;
   localparam int BW = 32;

   typedef struct packed {
      logic [FW-1:0]   flowid;
      logic [BW+3:0]   desc;
      logic            empty;
   } resp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tcp_buf_ring_ctrl_if #(.FLOWID_W(FW), .TCP_BUF_W(BW)) bus ();

   tcp_buf_ring_ctrl #(.FLOWID_W(FW), .RING_DEPTH(8), .TCP_BUF_W(BW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int    vectors     = 0;
   int    miscompares = 0;
   resp_t resp_q [$];
   logic  err_q  [$];
   logic  pend_hs = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: reject pulse one cycle after each post/adj handshake, responses on accept
   always @(negedge clk) begin
      resp_t e;
      if (pend_hs) begin
         if (err_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL adj_err: handshake with nothing queued");
         end else begin
            check("adj_err", 64'(bus.adj_err), 64'(err_q.pop_front()));
         end
      end else if (bus.adj_err === 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL adj_err_spurious: actual=1 required=0");
      end
      pend_hs = (bus.post_val && bus.post_rdy) || (bus.adj_val && bus.adj_rdy);
      if (bus.resp_val === 1'b1 && bus.resp_rdy === 1'b1) begin
         if (resp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL resp_unexpected: flowid=%0d buf=%0h", bus.resp_flowid, bus.resp_buf);
         end else begin
            e = resp_q.pop_front();
            check("resp", 64'({bus.resp_flowid, bus.resp_buf, bus.resp_empty}), 64'(e));
         end
      end
   end

   // Waits (bounded) for the selected ready; ends just after the granting edge
   task automatic wait_grant(input int which);
      int n = 0;
      logic r;
      @(negedge clk);
      r = (which == 0) ? bus.post_rdy : (which == 1) ? bus.req_rdy : bus.adj_rdy;
      while (!r && n < 50) begin
         @(negedge clk);
         r = (which == 0) ? bus.post_rdy : (which == 1) ? bus.req_rdy : bus.adj_rdy;
         n++;
      end
      if (!r) begin
         vectors++; miscompares++;
         $display("FAIL grant_timeout: source=%0d actual=0 required=1", which);
      end
      @(posedge clk); #1;
   endtask

   task automatic do_post(input logic [FW-1:0] f, input logic [BW-1:0] d, input logic exp_err);
      err_q.push_back(exp_err);
      bus.post_flowid = f; bus.post_buf = d; bus.post_val = 1'b1;
      wait_grant(0);
      bus.post_val = 1'b0;
   endtask

   task automatic do_req(input logic [FW-1:0] f, input logic [BW-1:0] d,
                         input logic [3:0] idx, input logic empty);
      resp_t e;
      e.flowid = f;
      e.desc   = empty ? '0 : {d, idx};
      e.empty  = empty;
      resp_q.push_back(e);
      bus.req_flowid = f; bus.req_val = 1'b1;
      wait_grant(1);
      bus.req_val = 1'b0;
      @(negedge clk);
      check("resp_latency", 64'(bus.resp_val), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic do_adj(input logic [FW-1:0] f, input logic [3:0] pidx,
                         input logic [3:0] cnt, input logic [15:0] left, input logic exp_err);
      err_q.push_back(exp_err);
      bus.adj_flowid = f; bus.adj_update = {32'h0, pidx, cnt, left}; bus.adj_val = 1'b1;
      wait_grant(2);
      bus.adj_val = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_g [6] = '{0, 1, 2, 0, 2, 0};
      int g;
      resp_t e;

      // ---------------- reset: readies held low even with valids up
      rst = 1'b1;
      bus.post_val = 1'b1; bus.req_val = 1'b1; bus.adj_val = 1'b1; bus.resp_rdy = 1'b1;
      bus.post_flowid = '0; bus.post_buf = '0; bus.req_flowid = '0;
      bus.adj_flowid = '0; bus.adj_update = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rdy_in_reset", 64'({bus.post_rdy, bus.req_rdy, bus.adj_rdy}), 64'd0);
      bus.post_val = 1'b0; bus.req_val = 1'b0; bus.adj_val = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", 64'({bus.resp_val, bus.resp_flowid, bus.resp_buf,
                                  bus.resp_empty, bus.adj_err}), 64'd0);
      @(posedge clk); #1;

      // ---------------- three posts to flow 2, head read returns the first
      do_post(3'd2, 32'hA000_0040, 1'b0);
      do_post(3'd2, 32'hA100_0041, 1'b0);
      do_post(3'd2, 32'hA200_0042, 1'b0);
      do_req(3'd2, 32'hA000_0040, 4'd0, 1'b0);

      // ---------------- empty flow 5, response stalled for 4 cycles
      bus.resp_rdy = 1'b0;
      do_req(3'd5, '0, 4'd0, 1'b1);
      bus.req_flowid = 3'd3; bus.req_val = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("stall_hold", 64'({bus.resp_val, bus.resp_flowid, bus.resp_buf, bus.resp_empty}),
               64'({1'b1, 3'd5, 36'd0, 1'b1}));
         check("stall_req_rdy", 64'(bus.req_rdy), 64'd0);
      end
      @(posedge clk); #1 bus.req_val = 1'b0;
      // a post during the wait must not disturb the captured response
      do_post(3'd5, 32'hD500_0005, 1'b0);
      @(negedge clk);
      check("stall_after_post", 64'({bus.resp_val, bus.resp_flowid, bus.resp_buf, bus.resp_empty}),
            64'({1'b1, 3'd5, 36'd0, 1'b1}));
      @(posedge clk); #1 bus.resp_rdy = 1'b1;
      @(posedge clk); #1;
      do_req(3'd5, 32'hD500_0005, 4'd0, 1'b0);

      // ---------------- flow 1: 9 posts (9th dropped), 8 retires, wrap bit
      for (int i = 0; i < 9; i++) do_post(3'd1, 32'hB000_0000 + 32'(i), (i == 8));
      do_req(3'd1, 32'hB000_0000, 4'd0, 1'b0);
      for (int i = 0; i < 8; i++) do_adj(3'd1, 4'(i), 4'd1, 16'd0, 1'b0);
      do_req(3'd1, '0, 4'd0, 1'b1);
      do_post(3'd1, 32'hC000_0001, 1'b0);
      do_req(3'd1, 32'hC000_0001, 4'd8, 1'b0);

      // ---------------- adjust rejections on flow 3
      do_post(3'd3, 32'hE300_0003, 1'b0);
      do_adj(3'd3, 4'd1, 4'd1, 16'd0, 1'b1);
      do_adj(3'd3, 4'd0, 4'd2, 16'd0, 1'b1);
      do_adj(3'd3, 4'd0, 4'd1, 16'd5, 1'b1);
      do_adj(3'd3, 4'd0, 4'd1, 16'd0, 1'b0);
      do_adj(3'd3, 4'd1, 4'd1, 16'd0, 1'b1);
      do_req(3'd3, '0, 4'd0, 1'b1);

      // ---------------- reset drops an in-flight response
      bus.resp_rdy = 1'b0;
      bus.req_flowid = 3'd6; bus.req_val = 1'b1;
      wait_grant(1);
      bus.req_val = 1'b0;
      @(negedge clk);
      check("inflight_before_rst", 64'(bus.resp_val), 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("inflight_after_rst", 64'(bus.resp_val), 64'd0);
      @(posedge clk); #1;

      // ---------------- fairness: all three valid for 6 cycles, response stalled
      err_q.push_back(1'b0); err_q.push_back(1'b0); err_q.push_back(1'b0);
      err_q.push_back(1'b1); err_q.push_back(1'b0);
      e.flowid = 3'd4; e.desc = {32'h9400_0004, 4'd0}; e.empty = 1'b0;
      resp_q.push_back(e);
      bus.post_flowid = 3'd4; bus.post_buf = 32'h9400_0004;
      bus.req_flowid  = 3'd4;
      bus.adj_flowid  = 3'd4; bus.adj_update = {32'h0, 4'd0, 4'd1, 16'd0};
      bus.post_val = 1'b1; bus.req_val = 1'b1; bus.adj_val = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         g = bus.post_rdy ? 0 : bus.req_rdy ? 1 : bus.adj_rdy ? 2 : 3;
         check("grant_order", 64'(g), 64'(exp_g[c]));
         @(posedge clk);
      end
      #1 bus.post_val = 1'b0; bus.req_val = 1'b0; bus.adj_val = 1'b0;
      @(negedge clk);
      check("resp_during_adj", 64'({bus.resp_val, bus.resp_buf}), 64'({1'b1, 32'h9400_0004, 4'd0}));
      @(posedge clk); #1 bus.resp_rdy = 1'b1;
      @(posedge clk); #1;

      // ---------------- flow 0: 20 post/adjust pairs across the index wrap
      for (int i = 0; i < 20; i++) begin
         do_post(3'd0, 32'hF000_0000 + 32'(i), 1'b0);
         do_req(3'd0, 32'hF000_0000 + 32'(i), 4'(i % 16), 1'b0);
         do_adj(3'd0, 4'(i % 16), 4'd1, 16'd0, 1'b0);
      end
      do_req(3'd0, '0, 4'd0, 1'b1);
      for (int j = 0; j < 9; j++) do_post(3'd0, 32'hD000_0000 + 32'(j), (j == 8));
      do_req(3'd0, 32'hD000_0000, 4'd4, 1'b0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("queues_drained", 64'(resp_q.size() + err_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
